// File: rtl/cache_pkg.sv
// Shared definitions for the cache and its physical-memory adapter.
package cache_pkg;

    localparam int LINE_BYTES = 32;
    localparam int NUM_BEATS  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit cache line transfer into a 4-beat, 64-bit memory burst
// and returns a single-cycle completion pulse to the cache.
module cacheline_adapter
    import cache_pkg::*;
#(
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pmem_address,
    input  logic                pmem_read,
    input  logic                pmem_write,
    input  logic [s_line-1:0]   pmem_wdata,
    output logic [s_line-1:0]   pmem_rdata,
    output logic                pmem_resp,
    output logic [31:0]         burst_address,
    output logic                burst_read,
    output logic                burst_write,
    output logic [s_burst-1:0]  burst_wdata,
    input  logic [s_burst-1:0]  burst_rdata,
    input  logic                burst_resp
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int CNT_W = $clog2(num_beats);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(num_beats - 1);

    adapter_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [s_line-1:0]    line_q, line_d;
    logic [31:0]          addr_q, addr_d;

    // Byte-offset bits of the request address never reach the bus.
    logic addr_offset_unused;
    assign addr_offset_unused = ^pmem_address[OFF_W-1:0];

    // State, beat counter, line buffer and address register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            addr_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic: accept a request in IDLE, count beats, finish with one DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                // Reads win when the cache raises both requests.
                if (pmem_read) begin
                    state_d = READ;
                    addr_d  = {pmem_address[31:OFF_W], {OFF_W{1'b0}}};
                    cnt_d   = '0;
                end else if (pmem_write) begin
                    state_d = WRITE;
                    addr_d  = {pmem_address[31:OFF_W], {OFF_W{1'b0}}};
                    cnt_d   = '0;
                    line_d  = pmem_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (burst_resp) begin
                    line_d[int'(cnt_q) * s_burst +: s_burst] = burst_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = READ;
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                // Clearing the address here keeps burst_address at zero while idle.
                state_d = IDLE;
                addr_d  = 32'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only; nothing flows from pmem_* to burst_* directly.
    always_comb begin
        pmem_rdata    = line_q;
        pmem_resp     = 1'b0;
        burst_address = addr_q;
        burst_read    = 1'b0;
        burst_write   = 1'b0;
        burst_wdata   = '0;
        case (state_q)
            IDLE: begin
                pmem_resp = 1'b0;
            end
            READ: begin
                burst_read = 1'b1;
            end
            WRITE: begin
                burst_write = 1'b1;
                burst_wdata = line_q[int'(cnt_q) * s_burst +: s_burst];
            end
            DONE: begin
                pmem_resp = 1'b1;
            end
            default: begin
                pmem_resp = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Responder for the cache's physical-memory port: accepts one 256-bit line read or write per request from the cache datapath/control pair, and carries it out as a 4-beat, 64-bit burst on the main-memory bus. On reads it assembles the beats into a line. On writes it slices the line into beats. It then returns a single-cycle `pmem_resp` to the cache. It sits between the L1 cache (`pmem_*` side) and the burst memory (`burst_*` side).

## Interface
Parameters:
- `s_line`, 256, line width in bits.
- `s_burst`, 64, beat width in bits.
- `num_beats`, `s_line/s_burst` (4), beats per line.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset: synchronous, active-low. Asserted (0) at a rising edge resets all state.
- `pmem_address`  in  32  line address from the cache; bits [4:0] are ignored.
- `pmem_read`  in  1  line-read request, level, held until `pmem_resp`.
- `pmem_write`  in  1  line-write request, level, held until `pmem_resp`.
- `pmem_wdata`  in  256  line to write, valid while `pmem_write` is high.
- `pmem_rdata`  out  256  assembled read line.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `burst_address`  out  32  line-aligned address, `{addr[31:5],5'b0}`.
- `burst_read`  out  1  burst read request, held for the whole burst.
- `burst_write`  out  1  burst write request, held for the whole burst.
- `burst_wdata`  out  64  current write beat.
- `burst_rdata`  in  64  read beat, valid when `burst_resp` is high.
- `burst_resp`  in  1  per-beat acknowledge, one per accepted or delivered beat.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Samples the request inputs.
  - `pmem_read` has priority if both `pmem_read` and `pmem_write` are high.
  - On either request, latches `{pmem_address[31:5],5'b0}` into the address register and clears the 2-bit beat counter.
  - On a write, also latches `pmem_wdata` into the 256-bit line buffer.
  - Transition to READ or WRITE.
- READ:
  - `burst_read`=1.
  - Each cycle with `burst_resp`=1: `burst_rdata` goes into line buffer bits [64k+63:64k], where k is the beat counter, and the counter increments.
  - On the beat with k=3: go to DONE.
- WRITE:
  - `burst_write`=1.
  - `burst_wdata` = line buffer bits [64k+63:64k].
  - Each `burst_resp` increments k.
  - On the beat with k=3: go to DONE.
- DONE:
  - `pmem_resp`=1 for exactly one cycle, then return to IDLE.
  - Requests are not sampled in DONE. The cache drops its request on the cycle it sees `pmem_resp`.
- `pmem_rdata` is driven from the line buffer. It is valid in DONE and holds until the next request is accepted.
- `burst_address` is constant for the whole burst. It is 0 in IDLE.
- `burst_resp` in IDLE or DONE is ignored.
- The beat counter is 2 bits, modulo 4. It never passes 3 within a burst.
- Reset values: state IDLE, counter 0, line buffer 0, address 0. All outputs are 0: `pmem_rdata`, `pmem_resp`, `burst_read`, `burst_write`, `burst_wdata`, `burst_address`.
- Reset mid-burst: the burst is abandoned with no `pmem_resp`. `burst_read`/`burst_write` are low in the cycle after the reset edge.

## Timing
- Request in IDLE at cycle 0 → `burst_read`/`burst_write` high from cycle 1.
- With zero-wait memory (`burst_resp` in cycles 1–4) → `pmem_resp` in cycle 5. This is the minimum latency of 5 cycles from request to response.
- Memory wait states add cycles one-for-one; there is no timeout.
- `burst_read`/`burst_write` drop in the cycle after the 4th `burst_resp`, i.e. the DONE cycle.
- The earliest next request is accepted in the IDLE cycle immediately after DONE.
- All outputs are registered or decoded from state only. There is no combinational path from `pmem_*` inputs to `burst_*` outputs.

## Structure
- Shared package `cache_pkg`:
  - `adapter_state_t` enum (IDLE, READ, WRITE, DONE).
  - Constants `LINE_BYTES`=32 and `NUM_BEATS`=4.
  - These are shared with cache control.
- Single module. No sub-module is warranted: the beat counter and line buffer live inline.

## Test plan
- Read, zero-wait:
  - Stimulus: `pmem_read`, `pmem_address`=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: `burst_address`=0x0000_1220; `pmem_resp` at cycle 5; `pmem_rdata`={44..44,33..33,22..22,11..11}.
- Write, zero-wait:
  - Stimulus: `pmem_write`, `pmem_wdata`={D,C,B,A} 64-bit words.
  - Required: `burst_wdata` is A,B,C,D on successive `burst_resp` cycles; `pmem_resp` at cycle 5; `burst_write` low in cycle 5.
- Wait states:
  - Stimulus: read with 2 idle cycles before each `burst_resp`.
  - Required: `pmem_resp` at cycle 13; `burst_address` stable throughout; data correct.
- Simultaneous requests:
  - Stimulus: `pmem_read` and `pmem_write` high together.
  - Required: a read burst is issued; `burst_write` stays 0.
- Stray beats and back-to-back:
  - Stimulus: `burst_resp` pulsed in IDLE, then a read, then a write requested in the IDLE cycle right after DONE.
  - Required: stray beats ignored; the read completes with 4 beats; the write is accepted immediately.
- Reset mid-burst:
  - Stimulus: `rst`=0 after beat 2 of a read.
  - Required: next cycle all outputs 0, state IDLE, no `pmem_resp`; a fresh read then completes normally.
